bus_line_cache: RTL
===================

Name: bus_line_cache

Overview:
- Direct-mapped, write-through, read-allocate line cache between the CPU bus master port and slow_ram.
- Each line is one full bus word (2**BUS_DATA_WIDTH_SHIFT bytes, 128 bits by default), addressed by line address.
- Read hits return in 1 cycle instead of the RAM LATENCY.
- Misses and all writes are forwarded to memory using the existing slow_ram handshake.

Parameters:
BUS_ADDRESS_WIDTH, 20, byte address width; line address is [BUS_ADDRESS_WIDTH-1:BUS_DATA_WIDTH_SHIFT]
BUS_DATA_WIDTH_SHIFT, 4, log2 bytes per line; data width = (2**SHIFT)*8
INDEX_BITS, 4, log2 number of lines (default 16)
TAG_BITS = BUS_ADDRESS_WIDTH-BUS_DATA_WIDTH_SHIFT-INDEX_BITS (derived localparam, not overridable)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-high
cpu_addr_i  in  AW-DS  CPU line address
cpu_data_i  in  DW  CPU write data
cpu_we_i  in  1  1 = write, 0 = read
cpu_req_i  in  1  request; held with addr/data/we stable until cpu_valid_o
cpu_data_o  out  DW  read data, valid when cpu_valid_o=1
cpu_valid_o  out  1  one-cycle completion pulse
flush_i  in  1  invalidate all lines
mem_addr_o  out  AW-DS  to slow_ram addr_i
mem_data_o  out  DW  to slow_ram data_i
mem_data_i  in  DW  from slow_ram data_o
mem_we_o  out  1  to slow_ram we_i
mem_valid_i  in  1  from slow_ram valid_o
hit_count_o  out  32  saturating read-hit counter
miss_count_o  out  32  saturating read-miss counter

Behaviour:
- Reset (async): all outputs 0, all valid bits 0, counters 0, state IDLE. Data and tag arrays are not reset.
- Reset mid-operation aborts the access; mem_we_o drops immediately. The line being filled stays invalid.
- Address split:
  - index = cpu_addr_i[INDEX_BITS-1:0]
  - tag = the upper TAG_BITS
- Hit = valid[index] && tag_array[index]==tag.
- FSM states: IDLE, READ_HIT, MISS_FILL, WRITE_THRU, RESP.
- IDLE, cpu_req_i=1:
  - read & hit -> READ_HIT. cpu_data_o<=line, cpu_valid_o=1 next cycle, hit_count++. Latency is 1 cycle from the request edge.
  - read & miss -> MISS_FILL. mem_addr_o<=cpu_addr_i, mem_we_o=0, miss_count++.
  - write -> WRITE_THRU. mem_addr_o<=cpu_addr_i, mem_data_o<=cpu_data_i, mem_we_o<=1.
- MISS_FILL: hold mem_* stable. On the mem_valid_i edge:
  - data_array[index]<=mem_data_i, tag written, valid set
  - cpu_data_o<=mem_data_i -> RESP
- WRITE_THRU: hold mem_* stable. On the mem_valid_i edge:
  - mem_we_o<=0
  - if hit, data_array[index]<=cpu_data_i (no allocate on write miss)
  - -> RESP
- READ_HIT/RESP: cpu_valid_o=1 for exactly one cycle -> IDLE. A new request is accepted the cycle after cpu_valid_o, not the same cycle.
- mem_addr_o/mem_data_o retain their last values in IDLE. mem_we_o is 1 only in WRITE_THRU.
- mem_valid_i outside MISS_FILL/WRITE_THRU is ignored.
- flush_i:
  - Sampled only in IDLE; clears all valid bits in 1 cycle.
  - Takes priority over cpu_req_i in that cycle; the request is then serviced the following cycle as a miss.
  - flush_i asserted outside IDLE is ignored; the master must hold it.
- Counters saturate at 32'hFFFF_FFFF and do not wrap. Writes are counted in neither counter.
- Read after write to the same line returns the new data: a hit updates the line, and a miss refills from memory, which already holds the data.

Decomposition:
- Shared package bus_pkg: bus width localparams (address width, data shift, derived data width) and the FSM state enum encoding. slow_ram and the cpu also use the width localparams.
- One natural sub-module: cache_line_store. It holds the data/tag/valid arrays with:
  - async-read lookup
  - single write port
  - bulk valid clear
- The top level holds the FSM, the mem/cpu registers and the counters.

Test Plan:
- Cold read of line 0x00002 (mem preloaded 128'h0061...0313, LATENCY 5) -> mem_addr_o=0x00002, one RAM access, data returned with cpu_valid_o; miss_count=1.
- Repeat read of 0x00002 -> cpu_valid_o exactly 1 cycle after request edge, no mem activity (mem_addr_o unchanged, mem_we_o=0); hit_count=1.
- Conflict: read 0x00002 then 0x00012 (same index, different tag) then 0x00002 -> three misses; each returns its own RAM contents.
- Write 128'hDEADC0DE to cached 0x00002 -> mem_we_o=1 until mem_valid_i, RAM updated; subsequent read hits and returns DEADC0DE. Write to uncached 0x00030 -> RAM updated, line not allocated; next read misses.
- flush_i pulse in IDLE after warm lines -> next read of 0x00002 misses; flush_i with simultaneous cpu_req_i -> flush first, request completes as miss.
- Assert rst_i during MISS_FILL (2 cycles into latency) -> mem_we_o=0, cpu_valid_o=0, counters 0 immediately; after release, read of same line misses.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared bus geometry and the line-cache FSM encoding used by the CPU,
// slow_ram and bus_line_cache.
package bus_pkg;

    localparam int BUS_AW = 20;
    localparam int BUS_DS = 4;
    localparam int BUS_DW = (2 ** BUS_DS) * 8;

    typedef logic [2:0] cache_state_t;

    localparam cache_state_t ST_IDLE       = 3'd0;
    localparam cache_state_t ST_READ_HIT   = 3'd1;
    localparam cache_state_t ST_MISS_FILL  = 3'd2;
    localparam cache_state_t ST_WRITE_THRU = 3'd3;
    localparam cache_state_t ST_RESP       = 3'd4;

endpackage

// File: rtl/cache_line_store.sv
// Direct-mapped line storage: data/tag arrays with async-read lookup,
// one write port and a single-cycle bulk invalidate.
module cache_line_store
    import bus_pkg::*;
#(
    parameter int INDEX_BITS = 4,
    parameter int TAG_BITS   = 12,
    parameter int DATA_WIDTH = BUS_DW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_BITS-1:0] lookup_index,
    input  logic [TAG_BITS-1:0]   lookup_tag,
    output logic                  hit,
    output logic [DATA_WIDTH-1:0] line_data,
    input  logic                  wr_en,
    input  logic [INDEX_BITS-1:0] wr_index,
    input  logic [TAG_BITS-1:0]   wr_tag,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  clear_all
);

    localparam int LINES = 2 ** INDEX_BITS;

    logic [DATA_WIDTH-1:0] data_r [LINES];
    logic [TAG_BITS-1:0]   tag_r  [LINES];
    logic [LINES-1:0]      valid_r;

    // Valid bits: cleared by reset or flush, set by any line write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= '0;
        end else if (clear_all) begin
            valid_r <= '0;
        end else if (wr_en) begin
            valid_r[wr_index] <= 1'b1;
        end
    end

    // Data and tag arrays carry no reset; valid_r alone qualifies them
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_r[wr_index] <= wr_data;
            tag_r[wr_index]  <= wr_tag;
        end
    end

    assign line_data = data_r[lookup_index];
    assign hit       = valid_r[lookup_index] && (tag_r[lookup_index] == lookup_tag);

endmodule

// File: rtl/bus_line_cache.sv
// Direct-mapped, write-through, read-allocate line cache between the CPU
// bus master and slow_ram; read hits complete one cycle after the request.
module bus_line_cache
    import bus_pkg::*;
#(
    parameter int BUS_ADDRESS_WIDTH    = BUS_AW,
    parameter int BUS_DATA_WIDTH_SHIFT = BUS_DS,
    parameter int INDEX_BITS           = 4
) (
    input  logic                                              clk_i,
    input  logic                                              rst_i,
    input  logic [BUS_ADDRESS_WIDTH-BUS_DATA_WIDTH_SHIFT-1:0] cpu_addr_i,
    input  logic [(2**BUS_DATA_WIDTH_SHIFT)*8-1:0]            cpu_data_i,
    input  logic                                              cpu_we_i,
    input  logic                                              cpu_req_i,
    output logic [(2**BUS_DATA_WIDTH_SHIFT)*8-1:0]            cpu_data_o,
    output logic                                              cpu_valid_o,
    input  logic                                              flush_i,
    output logic [BUS_ADDRESS_WIDTH-BUS_DATA_WIDTH_SHIFT-1:0] mem_addr_o,
    output logic [(2**BUS_DATA_WIDTH_SHIFT)*8-1:0]            mem_data_o,
    input  logic [(2**BUS_DATA_WIDTH_SHIFT)*8-1:0]            mem_data_i,
    output logic                                              mem_we_o,
    input  logic                                              mem_valid_i,
    output logic [31:0]                                       hit_count_o,
    output logic [31:0]                                       miss_count_o
);

    localparam int LINE_AW  = BUS_ADDRESS_WIDTH - BUS_DATA_WIDTH_SHIFT;
    localparam int DW       = (2 ** BUS_DATA_WIDTH_SHIFT) * 8;
    localparam int TAG_BITS = LINE_AW - INDEX_BITS;

    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

    cache_state_t          state_r;
    logic [DW-1:0]         cpu_data_r;
    logic                  cpu_valid_r;
    logic [LINE_AW-1:0]    mem_addr_r;
    logic [DW-1:0]         mem_data_r;
    logic                  mem_we_r;
    logic [31:0]           hit_count_r;
    logic [31:0]           miss_count_r;

    logic [INDEX_BITS-1:0] index_s;
    logic [TAG_BITS-1:0]   tag_s;
    logic                  hit_s;
    logic [DW-1:0]         line_s;
    logic                  wr_en_s;
    logic [DW-1:0]         wr_data_s;
    logic                  clear_s;

    assign index_s = cpu_addr_i[INDEX_BITS-1:0];
    assign tag_s   = cpu_addr_i[LINE_AW-1:INDEX_BITS];

    cache_line_store #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS),
        .DATA_WIDTH (DW)
    ) u_store (
        .clk          (clk_i),
        .rst          (rst_i),
        .lookup_index (index_s),
        .lookup_tag   (tag_s),
        .hit          (hit_s),
        .line_data    (line_s),
        .wr_en        (wr_en_s),
        .wr_index     (index_s),
        .wr_tag       (tag_s),
        .wr_data      (wr_data_s),
        .clear_all    (clear_s)
    );

    // Line-store write strobe: fills always allocate, write-through only updates a hit
    always_comb begin
        wr_en_s   = 1'b0;
        wr_data_s = cpu_data_i;
        clear_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                clear_s = flush_i;
            end
            ST_MISS_FILL: begin
                wr_en_s   = mem_valid_i;
                wr_data_s = mem_data_i;
            end
            ST_WRITE_THRU: begin
                if (mem_valid_i) begin
                    wr_en_s = hit_s;
                end else begin
                    wr_en_s = 1'b0;
                end
            end
            default: begin
                wr_en_s = 1'b0;
            end
        endcase
    end

    // Request FSM, bus-side registers and saturating hit/miss counters
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r      <= ST_IDLE;
            cpu_data_r   <= '0;
            cpu_valid_r  <= 1'b0;
            mem_addr_r   <= '0;
            mem_data_r   <= '0;
            mem_we_r     <= 1'b0;
            hit_count_r  <= 32'd0;
            miss_count_r <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // A flush wins this cycle; a held request then sees only misses
                    if (flush_i) begin
                        state_r <= ST_IDLE;
                    end else if (cpu_req_i) begin
                        if (cpu_we_i) begin
                            mem_addr_r <= cpu_addr_i;
                            mem_data_r <= cpu_data_i;
                            mem_we_r   <= 1'b1;
                            state_r    <= ST_WRITE_THRU;
                        end else if (hit_s) begin
                            cpu_data_r  <= line_s;
                            cpu_valid_r <= 1'b1;
                            hit_count_r <= sat_inc(hit_count_r);
                            state_r     <= ST_READ_HIT;
                        end else begin
                            mem_addr_r   <= cpu_addr_i;
                            mem_we_r     <= 1'b0;
                            miss_count_r <= sat_inc(miss_count_r);
                            state_r      <= ST_MISS_FILL;
                        end
                    end
                end
                ST_MISS_FILL: begin
                    if (mem_valid_i) begin
                        cpu_data_r  <= mem_data_i;
                        cpu_valid_r <= 1'b1;
                        state_r     <= ST_RESP;
                    end
                end
                ST_WRITE_THRU: begin
                    if (mem_valid_i) begin
                        mem_we_r    <= 1'b0;
                        cpu_valid_r <= 1'b1;
                        state_r     <= ST_RESP;
                    end
                end
                ST_READ_HIT, ST_RESP: begin
                    cpu_valid_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
                default: begin
                    cpu_valid_r <= 1'b0;
                    mem_we_r    <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign cpu_data_o   = cpu_data_r;
    assign cpu_valid_o  = cpu_valid_r;
    assign mem_addr_o   = mem_addr_r;
    assign mem_data_o   = mem_data_r;
    assign mem_we_o     = mem_we_r;
    assign hit_count_o  = hit_count_r;
    assign miss_count_o = miss_count_r;

endmodule
